// File: rtl/rvm_mem_responder_pkg.sv
// Shared types and constants for the rvm_mem_responder memory-side responder.
// Holds the responder FSM encoding, the read byte-enable code and the address fault helper.
package rvm_mem_responder_pkg;

  typedef enum logic [1:0] {
    RVM_MEMR_IDLE = 2'd0,
    RVM_MEMR_WAIT = 2'd1,
    RVM_MEMR_DONE = 2'd2
  } memr_state_t;

  localparam logic [3:0] RVM_MEM_BEN_READ = 4'b0000;

  // Unsigned wrap on the subtraction makes addresses below base fall out of range too.
  function automatic logic addr_fault(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] span);
    return (addr[1:0] != 2'b00) || ((addr - base) >= span);
  endfunction

endpackage

// File: rtl/rvm_mem_responder_if.sv
// Core-to-memory request/response bundle for rvm_mem_responder.
// The core drives the master side; the responder sits on the slave side.
interface rvm_mem_responder_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_c_en;
  logic [3:0]  mem_b_en;
  logic [31:0] mem_rdata;
  logic        mem_error;
  logic        mem_stall;

  modport master (
    output mem_addr, mem_wdata, mem_c_en, mem_b_en,
    input  mem_rdata, mem_error, mem_stall
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_c_en, mem_b_en,
    output mem_rdata, mem_error, mem_stall
  );
endinterface

// File: rtl/rvm_sram_bytewise.sv
// Synchronous single-port DEPTH x 32 RAM with per-byte write enables.
// rdata only updates on reads (en with wen == 0) and holds its value otherwise.
module rvm_sram_bytewise #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    wen,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] ram [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (wen == 4'b0000) begin
        rdata <= ram[addr];
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (wen[i]) ram[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/rvm_mem_responder.sv
// Memory-side responder: wait-state FSM, address/alignment fault detection, byte-enable RAM.
// Optional write protection of the low ROM_WORDS words is enabled by RVM_MEM_ROM_PROTECT_EN.
module rvm_mem_responder
  import rvm_mem_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_CYCLES = 1,
  parameter int          ROM_WORDS   = 256
) (
  input  logic               clk,
  input  logic               reset,
  rvm_mem_responder_if.slave mem
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [31:0] SPAN     = 32'(DEPTH * 4);
  localparam logic [31:0] ROM_LIM  = 32'(ROM_WORDS);
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
`ifdef RVM_MEM_ROM_PROTECT_EN
  localparam bit ROM_EN = 1'b1;
`else
  localparam bit ROM_EN = 1'b0;
`endif

  memr_state_t state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        enter_done;

  logic [31:0] addr_p0, wdata_p0;
  logic [3:0]  ben_p0;
  logic        fault_p0;

  logic [31:0] in_off;
  logic        fault_in;
  logic [31:0] acc_addr, acc_wdata;
  logic [3:0]  acc_ben;
  logic        acc_fault;

  logic        err_p1, rd_zero_p1;
  logic [31:0] sram_rdata;
  logic        sram_en;

  // Request decode: fault is evaluated on the live bus while IDLE.
  assign in_off   = mem.mem_addr - BASE_ADDR;
  assign fault_in = addr_fault(mem.mem_addr, BASE_ADDR, SPAN)
                  | (ROM_EN & (mem.mem_b_en != RVM_MEM_BEN_READ) & ((in_off >> 2) < ROM_LIM));

  // With zero wait states DONE is entered straight from IDLE, so the access uses the bus directly.
  assign acc_addr  = (state == RVM_MEMR_IDLE) ? mem.mem_addr  : addr_p0;
  assign acc_wdata = (state == RVM_MEMR_IDLE) ? mem.mem_wdata : wdata_p0;
  assign acc_ben   = (state == RVM_MEMR_IDLE) ? mem.mem_b_en  : ben_p0;
  assign acc_fault = (state == RVM_MEMR_IDLE) ? fault_in      : fault_p0;

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    enter_done = 1'b0;
    case (state)
      RVM_MEMR_IDLE: begin
        if (mem.mem_c_en) begin
          if (WAIT_CYCLES > 0) begin
            state_nx = RVM_MEMR_WAIT;
            cnt_nx   = CNT_INIT;
          end else begin
            state_nx   = RVM_MEMR_DONE;
            enter_done = 1'b1;
          end
        end
      end
      RVM_MEMR_WAIT: begin
        if (!mem.mem_c_en) begin
          state_nx = RVM_MEMR_IDLE;
        end else if (cnt == 4'd0) begin
          state_nx   = RVM_MEMR_DONE;
          enter_done = 1'b1;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      default: state_nx = RVM_MEMR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RVM_MEMR_IDLE;
      cnt        <= 4'd0;
      err_p1     <= 1'b0;
      rd_zero_p1 <= 1'b1;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      err_p1 <= enter_done & acc_fault;
      if (enter_done) begin
        if (acc_fault) rd_zero_p1 <= 1'b1;
        else if (acc_ben == RVM_MEM_BEN_READ) rd_zero_p1 <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == RVM_MEMR_IDLE && mem.mem_c_en) begin
      addr_p0  <= mem.mem_addr;
      wdata_p0 <= mem.mem_wdata;
      ben_p0   <= mem.mem_b_en;
      fault_p0 <= fault_in;
    end
  end

  // Access stage: RAM is touched only on the edge that enters DONE, and never under reset.
  assign sram_en = enter_done & ~acc_fault & ~reset;

  rvm_sram_bytewise #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_sram (
    .clk   (clk),
    .en    (sram_en),
    .wen   (acc_ben),
    .addr  (AW'((acc_addr - BASE_ADDR) >> 2)),
    .wdata (acc_wdata),
    .rdata (sram_rdata)
  );

  // Response: the RAM output register holds the last read; a fault or reset forces zero.
  assign mem.mem_rdata = rd_zero_p1 ? 32'h0 : sram_rdata;
  assign mem.mem_error = err_p1;
  assign mem.mem_stall = mem.mem_c_en & (state != RVM_MEMR_DONE);

endmodule

// File: tb/tb_rvm_mem_responder.sv
// Self-checking bench for rvm_mem_responder: three instances (1, 3 and 0 wait states),
// a directed vector table, multi-cycle abort/reset/back-to-back sequences and a random model phase.
module tb_rvm_mem_responder;

`ifdef RVM_MEM_ROM_PROTECT_EN
  localparam bit ROM = 1'b1;
`else
  localparam bit ROM = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [3:0]  ben   [3];
  logic        cen   [3];
  wire  [31:0] rdata [3];
  wire         err   [3];
  wire         stall [3];

  rvm_mem_responder_if bus0 ();
  rvm_mem_responder_if bus1 ();
  rvm_mem_responder_if bus2 ();

  assign bus0.mem_addr = addr[0];  assign bus0.mem_wdata = wdata[0];
  assign bus0.mem_b_en = ben[0];   assign bus0.mem_c_en  = cen[0];
  assign bus1.mem_addr = addr[1];  assign bus1.mem_wdata = wdata[1];
  assign bus1.mem_b_en = ben[1];   assign bus1.mem_c_en  = cen[1];
  assign bus2.mem_addr = addr[2];  assign bus2.mem_wdata = wdata[2];
  assign bus2.mem_b_en = ben[2];   assign bus2.mem_c_en  = cen[2];
  assign rdata[0] = bus0.mem_rdata; assign err[0] = bus0.mem_error; assign stall[0] = bus0.mem_stall;
  assign rdata[1] = bus1.mem_rdata; assign err[1] = bus1.mem_error; assign stall[1] = bus1.mem_stall;
  assign rdata[2] = bus2.mem_rdata; assign err[2] = bus2.mem_error; assign stall[2] = bus2.mem_stall;

  rvm_mem_responder #(.BASE_ADDR(32'h0), .DEPTH(1024), .WAIT_CYCLES(1), .ROM_WORDS(256))
    u_dut0 (.clk(clk), .reset(rst[0]), .mem(bus0));
  rvm_mem_responder #(.BASE_ADDR(32'h0), .DEPTH(1024), .WAIT_CYCLES(3), .ROM_WORDS(256))
    u_dut1 (.clk(clk), .reset(rst[1]), .mem(bus1));
  rvm_mem_responder #(.BASE_ADDR(32'h0), .DEPTH(1024), .WAIT_CYCLES(0), .ROM_WORDS(256))
    u_dut2 (.clk(clk), .reset(rst[2]), .mem(bus2));

  int n_chk  = 0;
  int n_fail = 0;

  function automatic int wait_of(input int k);
    case (k)
      0:       return 1;
      1:       return 3;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // Called at posedge+1; presents one request and returns at posedge+1 after it completes.
  task automatic run_txn(input int k, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, input bit keep,
                         output logic [31:0] rd, output logic e, output int stalls);
    bit done;
    cen[k] = 1'b1; addr[k] = a; wdata[k] = d; ben[k] = be;
    stalls = 0; done = 1'b0; rd = 'x; e = 1'bx;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (stall[k]) stalls++;
      else begin
        rd = rdata[k]; e = err[k]; done = 1'b1;
      end
    end
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL timeout: dut%0d addr %08h never completed", k, a);
    end
    @(posedge clk); #1;
    if (!keep) cen[k] = 1'b0;
  endtask

  task automatic txn_chk(input int k, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, input logic ee, input logic [31:0] er,
                         input bit cr, input bit keep);
    logic [31:0] rd; logic e; int st;
    run_txn(k, a, d, be, keep, rd, e, st);
    check($sformatf("stall_cycles dut%0d a=%08h", k, a), 32'(st), 32'(wait_of(k) + 1));
    check($sformatf("error dut%0d a=%08h be=%h", k, a, be), {31'b0, e}, {31'b0, ee});
    if (cr) check($sformatf("rdata dut%0d a=%08h be=%h", k, a, be), rd, er);
    check($sformatf("error_clear dut%0d a=%08h", k, a), {31'b0, err[k]}, 32'h0);
  endtask

  // Behavioural memory for dut0: word array plus a per-word "known" flag.
  logic [31:0] mdl  [1024];
  bit          mval [1024];
  logic [31:0] m_rd;
  bit          m_rd_known;

  task automatic model_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bit   flt;
    int   idx;
    flt = (a % 4 != 0) || (a >= 32'd4096) || (ROM && be != 4'h0 && (a / 4) < 256);
    idx = int'(a / 4) % 1024;
    if (flt) begin
      m_rd = 32'h0; m_rd_known = 1'b1;
    end else if (be == 4'h0) begin
      m_rd = mdl[idx]; m_rd_known = mval[idx];
    end else begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
      mval[idx] = mval[idx] || (be == 4'hF);
    end
    txn_chk(0, a, d, be, flt, m_rd, m_rd_known, 1'b0);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic        ee;
    logic [31:0] er;
    bit          cr;
  } vec_t;

  vec_t tbl [14];

  logic [31:0] pool [12];

  initial begin
    tbl[0]  = '{32'h10,       32'hDEADBEEF, 4'hF, ROM,  32'h0,                          1'b1};
    tbl[1]  = '{32'h10,       32'h0,        4'h0, 1'b0, 32'hDEADBEEF,                   !ROM};
    tbl[2]  = '{32'h20,       32'h11223344, 4'hF, ROM,  ROM ? 32'h0 : 32'hDEADBEEF,     1'b1};
    tbl[3]  = '{32'h20,       32'hAABBCCDD, 4'h5, ROM,  ROM ? 32'h0 : 32'hDEADBEEF,     1'b1};
    tbl[4]  = '{32'h20,       32'h0,        4'h0, 1'b0, 32'h11BB33DD,                   !ROM};
    tbl[5]  = '{32'h2,        32'h0,        4'h0, 1'b1, 32'h0,                          1'b1};
    tbl[6]  = '{32'h1000,     32'h0,        4'h0, 1'b1, 32'h0,                          1'b1};
    tbl[7]  = '{32'h1000,     32'h55555555, 4'hF, 1'b1, 32'h0,                          1'b1};
    tbl[8]  = '{32'h10,       32'h0,        4'h0, 1'b0, 32'hDEADBEEF,                   !ROM};
    tbl[9]  = '{32'hFFFFFFFC, 32'h0,        4'h0, 1'b1, 32'h0,                          1'b1};
    tbl[10] = '{32'h3FC,      32'h0BADF00D, 4'hF, ROM,  32'h0,                          1'b1};
    tbl[11] = '{32'h400,      32'hCAFEBABE, 4'hF, 1'b0, 32'h0,                          1'b1};
    tbl[12] = '{32'h400,      32'h0,        4'h0, 1'b0, 32'hCAFEBABE,                   1'b1};
    tbl[13] = '{32'h3FC,      32'h0,        4'h0, 1'b0, 32'h0BADF00D,                   !ROM};

    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; cen[k] = 1'b0; addr[k] = '0; wdata[k] = '0; ben[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;

    // Reset state and combinational stall
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset rdata dut%0d", k), rdata[k], 32'h0);
      check($sformatf("reset error dut%0d", k), {31'b0, err[k]}, 32'h0);
      check($sformatf("reset stall idle dut%0d", k), {31'b0, stall[k]}, 32'h0);
      cen[k] = 1'b1; #1;
      check($sformatf("stall follows c_en dut%0d", k), {31'b0, stall[k]}, 32'h1);
      cen[k] = 1'b0;
    end
    @(posedge clk); #1;

    // Directed table on the one-wait-state instance
    for (int i = 0; i < 14; i++)
      txn_chk(0, tbl[i].a, tbl[i].d, tbl[i].be, tbl[i].ee, tbl[i].er, tbl[i].cr, 1'b0);

    // Abort during WAIT (three wait states)
    txn_chk(1, 32'h40, 32'h12345678, 4'hF, 1'b0, 32'h0, 1'b1, 1'b0);
    cen[1] = 1'b1; addr[1] = 32'h40; wdata[1] = 32'hFFFFFFFF; ben[1] = 4'hF;
    repeat (2) @(posedge clk); #1;
    check("abort stall in wait", {31'b0, stall[1]}, 32'h1);
    cen[1] = 1'b0;
    repeat (5) @(posedge clk); #1;
    check("abort no error", {31'b0, err[1]}, 32'h0);
    txn_chk(1, 32'h40, 32'h0, 4'h0, 1'b0, 32'h12345678, 1'b1, 1'b0);

    // Reset on the edge that would have completed the write
    cen[1] = 1'b1; addr[1] = 32'h40; wdata[1] = 32'hFFFFFFFF; ben[1] = 4'hF;
    repeat (3) @(posedge clk); #1;
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0; cen[1] = 1'b0;
    check("reset mid-wait error", {31'b0, err[1]}, 32'h0);
    check("reset mid-wait rdata", rdata[1], 32'h0);
    txn_chk(1, 32'h40, 32'h0, 4'h0, 1'b0, 32'h12345678, 1'b1, 1'b0);

    // Zero wait states, back-to-back reads with c_en held high
    txn_chk(2, 32'h0, 32'hA0A0A0A0, 4'hF, 1'b0, 32'h0, 1'b1, 1'b0);
    txn_chk(2, 32'h4, 32'h0B0B0B0B, 4'hF, 1'b0, 32'h0, 1'b1, 1'b0);
    txn_chk(2, 32'h0, 32'h0, 4'h0, 1'b0, 32'hA0A0A0A0, 1'b1, 1'b1);
    txn_chk(2, 32'h4, 32'h0, 4'h0, 1'b0, 32'h0B0B0B0B, 1'b1, 1'b0);
    @(posedge clk); #1;
    check("b2b no extra txn stall", {31'b0, stall[2]}, 32'h0);
    check("b2b rdata holds", rdata[2], 32'h0B0B0B0B);

    // Random phase against the behavioural model
    for (int i = 0; i < 1024; i++) mval[i] = 1'b0;
    for (int i = 0; i < 8; i++) pool[i] = 32'h800 + 32'(4 * i);
    for (int i = 0; i < 4; i++) pool[8 + i] = 32'h100 + 32'(4 * i);
    model_txn(32'h2, 32'h0, 4'h0);
    for (int i = 0; i < 12; i++) model_txn(pool[i], $urandom, 4'hF);
    for (int i = 0; i < 80; i++) begin
      logic [31:0] a;
      logic [3:0]  be;
      int          sel, op;
      sel = $urandom_range(0, 9);
      a   = pool[$urandom_range(0, 11)];
      if (sel == 8) a = a | 32'($urandom_range(1, 3));
      if (sel == 9) a = 32'h1000 + (32'($urandom) & 32'h7FFF_FFFC);
      op  = $urandom_range(0, 3);
      be  = (op < 2) ? 4'h0 : (op == 2) ? 4'hF : 4'($urandom_range(1, 15));
      model_txn(a, $urandom, be);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
